rect_finder: RTL and testbench
==============================

RECT_FINDER -- requirements
Module: rect_finder

Interface
REQ-001 THRESH, default 3, minimum corner-ones count for a hit; legal values 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to scan m_in; sampled only in IDLE.
REQ-005 m_in  input  16  4x4 binary matrix; element (r,c) at bit 15-(4r+c), so (0,0) is the MSB.
REQ-006 busy  output  1  high in SCAN and DONE.
REQ-007 rect_valid  output  1  result available; high only in DONE.
REQ-008 out_ready  input  1  downstream (flip stage) accepts result when rect_valid and out_ready are both high.
REQ-009 found  output  1  1 = rectangle meets THRESH; 0 = none exists.
REQ-010 r1, r2, c1, c2  output  2 each  rectangle corners; r1<r2 and c1<c2 when found=1.
REQ-011 m_hold  output  16  matrix captured at start; drives the flip stage's m_in.
REQ-012 corner_cnt  output  3  ones count at the four corners of the reported rectangle (0..4).

Function
REQ-013 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-014 IDLE with start=1: capture m_in into m_hold, reset candidate index k to 0, go to SCAN; with start=0, stay in IDLE.
REQ-015 Candidates SHALL be ordered with r1 outermost (0..2), then r2 (r1+1..3), then c1 (0..2), then c2 (c1+1..3) innermost; 36 candidates, k=0..35.
REQ-016 SCAN SHALL evaluate exactly one candidate per cycle: the popcount of the bits at (r1,c1), (r1,c2), (r2,c1) and (r2,c2) in m_hold.
REQ-017 When popcount >= THRESH: register r1/r2/c1/c2, set corner_cnt = popcount and found=1, go to DONE.
REQ-018 When k=35 and there is no hit: set found=0, r1=r2=c1=c2=0 and corner_cnt=0, go to DONE.
REQ-019 Timing: start is sampled at edge T; candidate k is evaluated in cycle T+1+k; on a hit at k, rect_valid is high from cycle T+2+k; with no hit, rect_valid is high from cycle T+37.
REQ-020 DONE SHALL hold rect_valid and all result outputs stable until out_ready=1, then return to IDLE; the next start can be accepted in the cycle after the handshake.
REQ-021 start asserted in SCAN or DONE SHALL be ignored and SHALL NOT change m_hold.
REQ-022 m_hold SHALL change only on start acceptance in IDLE.
REQ-023 The candidate index SHALL NOT wrap past 35; the first hit in scan order wins, and later candidates are not evaluated.

Reset
REQ-024 With rst_n=0 at a clock edge, the next state SHALL be IDLE; busy=0, rect_valid=0, found=0, r1=r2=c1=c2=0, corner_cnt=0, m_hold=16'h0000, k=0.
REQ-025 Reset in SCAN or DONE SHALL abort the operation with no result handshake; reset takes priority over start in the same cycle.

Verification
REQ-026 m_in=16'hC800 (corners (0,0), (0,1), (1,0) set), start at T -> rect_valid at T+2, found=1, r1=0, r2=1, c1=0, c2=1, corner_cnt=3.
REQ-027 m_in=16'h0000 -> rect_valid at T+37, found=0, all coordinates 0, corner_cnt=0.
REQ-028 m_in=16'h0032 -> hit at k=35, rect_valid at T+37, found=1, r1=2, r2=3, c1=2, c2=3, corner_cnt=3.
REQ-029 m_in=16'hFFFF with out_ready=0 for 5 cycles -> rect_valid held, outputs stable with corner_cnt=4; start pulses during the hold are ignored; handshake returns to IDLE.
REQ-030 Reset asserted at cycle T+10 of a 16'h0000 scan -> IDLE next cycle, all outputs at reset values, no rect_valid.
REQ-031 THRESH=4 with m_in=16'hC800 -> found=0 at T+37.

Source files
------------

// File: rtl/rect_finder.sv
// rect_finder: scans a captured 4x4 binary matrix for the first axis-aligned
// rectangle whose four corners hold at least THRESH ones.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   start       scan request, only looked at in IDLE
//   m_in        4x4 matrix, element (r,c) at bit 15-(4r+c)
//   out_ready   downstream accepts the result when rect_valid is high
//   busy        high in SCAN and DONE
//   rect_valid  result available (DONE only)
//   found       1 = rectangle meets THRESH, 0 = none exists
//   r1,r2,c1,c2 rectangle corner rows/columns (all 0 when not found)
//   m_hold      matrix captured at start
//   corner_cnt  ones count at the four corners of the reported rectangle
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | evaluating one candidate rectangle per cycle, k = 0..35
// DONE  | result held until out_ready
module rect_finder #(
    parameter int THRESH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] m_in,
    input  logic        out_ready,
    output logic        busy,
    output logic        rect_valid,
    output logic        found,
    output logic [1:0]  r1,
    output logic [1:0]  r2,
    output logic [1:0]  c1,
    output logic [1:0]  c2,
    output logic [15:0] m_hold,
    output logic [2:0]  corner_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [2:0] THR = 3'(THRESH);

    state_t      state, state_next;
    logic [5:0]  k;
    logic [1:0]  sr1, sr2, sc1, sc2;
    logic [2:0]  pop;
    logic        hit, last;

    // Element (r,c) sits at bit 15-(4r+c), which is simply ~{r,c}.
    always_comb begin
        pop = 3'(m_hold[~{sr1, sc1}]) + 3'(m_hold[~{sr1, sc2}])
            + 3'(m_hold[~{sr2, sc1}]) + 3'(m_hold[~{sr2, sc2}]);
        hit  = (pop >= THR);
        last = (k == 6'd35);
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        rect_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (hit || last) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                rect_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            sr1        <= 2'd0;
            sr2        <= 2'd1;
            sc1        <= 2'd0;
            sc2        <= 2'd1;
            m_hold     <= '0;
            found      <= 1'b0;
            r1         <= '0;
            r2         <= '0;
            c1         <= '0;
            c2         <= '0;
            corner_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_hold <= m_in;
                        k      <= '0;
                        sr1    <= 2'd0;
                        sr2    <= 2'd1;
                        sc1    <= 2'd0;
                        sc2    <= 2'd1;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        found      <= 1'b1;
                        r1         <= sr1;
                        r2         <= sr2;
                        c1         <= sc1;
                        c2         <= sc2;
                        corner_cnt <= pop;
                    end else if (last) begin
                        found      <= 1'b0;
                        r1         <= '0;
                        r2         <= '0;
                        c1         <= '0;
                        c2         <= '0;
                        corner_cnt <= '0;
                    end else begin
                        // Step to the next candidate: c2 innermost, then c1,
                        // then r2, then r1. k=35 is the last, so no wrap.
                        k <= k + 6'd1;
                        if (sc2 != 2'd3) begin
                            sc2 <= sc2 + 2'd1;
                        end else if (sc1 != 2'd2) begin
                            sc1 <= sc1 + 2'd1;
                            sc2 <= sc1 + 2'd2;
                        end else begin
                            sc1 <= 2'd0;
                            sc2 <= 2'd1;
                            if (sr2 != 2'd3) begin
                                sr2 <= sr2 + 2'd1;
                            end else begin
                                sr1 <= sr1 + 2'd1;
                                sr2 <= sr1 + 2'd2;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_finder.sv
module tb_rect_finder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, out_ready;
    logic [15:0] m_in;
    logic        busy, rect_valid, found;
    logic [1:0]  r1, r2, c1, c2;
    logic [15:0] m_hold;
    logic [2:0]  corner_cnt;

    logic        start4, out_ready4;
    logic [15:0] m_in4;
    logic        busy4, rect_valid4, found4;
    logic [1:0]  r1_4, r2_4, c1_4, c2_4;
    logic [15:0] m_hold4;
    logic [2:0]  corner_cnt4;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    rect_finder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m_in(m_in), .out_ready(out_ready),
        .busy(busy), .rect_valid(rect_valid), .found(found),
        .r1(r1), .r2(r2), .c1(c1), .c2(c2), .m_hold(m_hold), .corner_cnt(corner_cnt)
    );

    rect_finder #(.THRESH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .m_in(m_in4), .out_ready(out_ready4),
        .busy(busy4), .rect_valid(rect_valid4), .found(found4),
        .r1(r1_4), .r2(r2_4), .c1(c1_4), .c2(c2_4), .m_hold(m_hold4), .corner_cnt(corner_cnt4)
    );

    typedef struct {
        logic [15:0] m;
        logic        f;
        logic [1:0]  r1, r2, c1, c2;
        logic [2:0]  cnt;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Presents start for one edge (edge T); returns at the negedge of cycle T+1.
    task automatic kick(input logic [15:0] m);
        @(negedge clk);
        m_in  = m;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_in  = 16'h0000;
    endtask

    // lat = n means rect_valid first seen in cycle T+n.
    task automatic wait_valid(input int from, output int lat);
        lat = from;
        while (!rect_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        logic saw_valid;

        vecs[0] = '{16'hC800, 1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 3'd3, 2};
        vecs[1] = '{16'h0000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 37};
        vecs[2] = '{16'h0032, 1'b1, 2'd2, 2'd3, 2'd2, 2'd3, 3'd3, 37};
        vecs[3] = '{16'hFFFF, 1'b1, 2'd0, 2'd1, 2'd0, 2'd1, 3'd4, 2};
        vecs[4] = '{16'h8421, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 37};
        vecs[5] = '{16'h0301, 1'b1, 2'd1, 2'd3, 2'd2, 2'd3, 3'd3, 31};
        vecs[6] = '{16'h0660, 1'b1, 2'd1, 2'd2, 2'd1, 2'd2, 3'd4, 23};

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; m_in = 16'h0000;
        start4 = 1'b0; out_ready4 = 1'b0; m_in4 = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rect_valid, 0);
        chk("rst_found", found, 0);
        chk("rst_coords", {r1, r2, c1, c2}, 0);
        chk("rst_cnt", corner_cnt, 0);
        chk("rst_mhold", m_hold, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            kick(vecs[i].m);
            chk($sformatf("v%0d_busy", i), busy, 1);
            wait_valid(1, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_found", i), found, vecs[i].f);
            chk($sformatf("v%0d_r1", i), r1, vecs[i].r1);
            chk($sformatf("v%0d_r2", i), r2, vecs[i].r2);
            chk($sformatf("v%0d_c1", i), c1, vecs[i].c1);
            chk($sformatf("v%0d_c2", i), c2, vecs[i].c2);
            chk($sformatf("v%0d_cnt", i), corner_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_mhold", i), m_hold, vecs[i].m);
            handshake();
            chk($sformatf("v%0d_idle", i), busy, 0);
        end

        // start during SCAN must not disturb m_hold or the scan
        kick(16'h0000);
        repeat (4) @(negedge clk);
        start = 1'b1; m_in = 16'hFFFF;
        @(negedge clk);
        start = 1'b0; m_in = 16'h0000;
        chk("scanign_mhold", m_hold, 16'h0000);
        wait_valid(6, lat);
        chk("scanign_lat", lat, 37);
        chk("scanign_found", found, 0);
        handshake();

        // DONE held with out_ready low; start pulses ignored
        kick(16'hFFFF);
        wait_valid(1, lat);
        chk("hold_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            start = i[0]; m_in = 16'h1234;
            @(negedge clk);
            chk($sformatf("hold%0d_valid", i), rect_valid, 1);
            chk($sformatf("hold%0d_cnt", i), corner_cnt, 4);
            chk($sformatf("hold%0d_mhold", i), m_hold, 16'hFFFF);
            chk($sformatf("hold%0d_coords", i), {r1, r2, c1, c2}, 8'b00010001);
        end
        start = 1'b0; m_in = 16'h0000;
        handshake();
        chk("hold_idle", busy, 0);
        chk("hold_valid_low", rect_valid, 0);
        // back-to-back start right after the handshake
        kick(16'hC800);
        wait_valid(1, lat);
        chk("b2b_lat", lat, 2);
        chk("b2b_cnt", corner_cnt, 3);
        handshake();

        // reset in the middle of a scan, with start also high
        kick(16'h0000);
        repeat (9) @(negedge clk);
        rst_n = 1'b0; start = 1'b1; m_in = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", rect_valid, 0);
        chk("abort_mhold", m_hold, 0);
        chk("abort_found", found, 0);
        chk("abort_cnt", corner_cnt, 0);
        rst_n = 1'b1; start = 1'b0; m_in = 16'h0000;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | rect_valid | busy;
        end
        chk("abort_quiet", saw_valid, 0);

        // THRESH=4 instance: three corners are not enough
        @(negedge clk);
        m_in4 = 16'hC800; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!rect_valid4 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("th4_lat", lat, 37);
        chk("th4_found", found4, 0);
        chk("th4_cnt", corner_cnt4, 0);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
